// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, word layout, status bits and
// converter state encoding for the FPU integer path.
package fp_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;
  localparam int SIG_W  = MANT_W + 1;

  // Exponent field at which E reaches 31 (saturation)
  localparam logic [EXP_W-1:0] SAT_EXP = 6'(BIAS + 31);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_word_t;

  localparam int ST_OVF  = 3;
  localparam int ST_INX  = 2;
  localparam int ST_ZERO = 1;
  localparam int ST_NEG  = 0;

  typedef enum logic [1:0] {
    F2I_IDLE,
    F2I_SHIFT,
    F2I_ROUND
  } f2i_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_UNDER,
    CLS_OVER
  } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits an FPU word into sign, unbiased
// exponent, significand {1,m} and magnitude class.
module fp_unpack
  import fp_pkg::*;
(
  input  fp_word_t                op_i,
  output logic                    sign_o,
  output logic signed [EXP_W:0]   exp_o,
  output logic [SIG_W-1:0]        sig_o,
  output fp_class_t               cls_o
);

  logic is_zero;
  logic is_under;
  logic is_over;

  // Field split and classification by exponent range
  always_comb begin
    sign_o   = op_i.sign;
    exp_o    = $signed({1'b0, op_i.exp})
             - $signed(7'(BIAS));
    sig_o    = {1'b1, op_i.mant};
    is_zero  = (op_i.exp == '0);
    is_under = !is_zero
             && (op_i.exp < 6'(BIAS));
    is_over  = (op_i.exp >= SAT_EXP);
    unique case (1'b1)
      is_zero:  cls_o = CLS_ZERO;
      is_under: cls_o = CLS_UNDER;
      is_over:  cls_o = CLS_OVER;
      default:  cls_o = CLS_NORM;
    endcase
  end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: iterative FPU-word to int32 converter.
// Build option FP2INT_ROUND_EN: round-half-away, else truncate.
module fp_to_int
  import fp_pkg::*;
(
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_out,
  output logic [3:0]  status_out
);

  fp_word_t             op_w;
  logic                 u_sign;
  logic signed [EXP_W:0] u_exp;
  logic [SIG_W-1:0]     u_sig;
  fp_class_t            u_cls;

  assign op_w = op_in;

  fp_unpack u_unpack (
    .op_i   (op_w),
    .sign_o (u_sign),
    .exp_o  (u_exp),
    .sig_o  (u_sig),
    .cls_o  (u_cls)
  );

  f2i_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mag_q, mag_d;
  logic        rnd_q, rnd_d;
  logic        stk_q, stk_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        min_q, min_d;
  fp_class_t   cls_q, cls_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  stat_q, stat_d;

  logic        inc;
  logic [32:0] rmag;
  logic [31:0] fres;
  logic        fovf;
  logic        finx;

  // Round, sign and saturate the aligned magnitude
  always_comb begin
`ifdef FP2INT_ROUND_EN
    inc = rnd_q;
`else
    inc = 1'b0;
`endif
    rmag = {1'b0, mag_q} + {32'b0, inc};
    fres = '0;
    fovf = 1'b0;
    finx = 1'b0;
    if (cls_q == CLS_OVER && min_q) begin
      fres = 32'h8000_0000;
    end else if (cls_q == CLS_OVER) begin
      fres = sign_q ? 32'h8000_0000
                    : 32'h7FFF_FFFF;
      fovf = 1'b1;
    end else if (!sign_q
                 && rmag >= 33'h0_8000_0000) begin
      fres = 32'h7FFF_FFFF;
      fovf = 1'b1;
    end else if (sign_q
                 && rmag > 33'h0_8000_0000) begin
      fres = 32'h8000_0000;
      fovf = 1'b1;
    end else begin
      fres = sign_q ? (~rmag[31:0] + 32'd1)
                    : rmag[31:0];
      finx = rnd_q | stk_q;
    end
  end

  // Conversion sequencer: classify, shift, finish
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    rnd_d   = rnd_q;
    stk_d   = stk_q;
    left_d  = left_q;
    sign_d  = sign_q;
    min_d   = min_q;
    cls_d   = cls_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    stat_d  = stat_q;
    unique case (state_q)
      F2I_IDLE: begin
        if (start) begin
          sign_d = u_sign;
          cls_d  = u_cls;
          min_d  = op_w.sign
                && op_w.exp == SAT_EXP
                && op_w.mant == '0;
          cnt_d  = '0;
          mag_d  = '0;
          rnd_d  = 1'b0;
          stk_d  = 1'b0;
          left_d = 1'b0;
          busy_d = 1'b1;
          unique case (u_cls)
            CLS_NORM: begin
              mag_d = {6'b0, u_sig};
              if (u_exp >= 7'sd25) begin
                left_d = 1'b1;
                cnt_d  = 5'(u_exp - 7'sd25);
              end else begin
                cnt_d  = 5'(7'sd25 - u_exp);
              end
            end
            CLS_UNDER: begin
              rnd_d = (u_exp == -7'sd1);
              stk_d = rnd_d ? |op_w.mant
                            : 1'b1;
            end
            default: ;
          endcase
          state_d = (cnt_d == '0) ? F2I_ROUND
                                  : F2I_SHIFT;
        end
      end
      F2I_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[30:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[31:1]};
          rnd_d = mag_q[0];
          stk_d = stk_q | rnd_q;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = F2I_ROUND;
      end
      F2I_ROUND: begin
        res_d           = fres;
        stat_d[ST_OVF]  = fovf;
        stat_d[ST_INX]  = finx;
        stat_d[ST_ZERO] = (fres == '0);
        stat_d[ST_NEG]  = fres[31];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = F2I_IDLE;
      end
      default: state_d = F2I_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= F2I_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      rnd_q   <= 1'b0;
      stk_q   <= 1'b0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      min_q   <= 1'b0;
      cls_q   <= CLS_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      rnd_q   <= rnd_d;
      stk_q   <= stk_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      min_q   <= min_d;
      cls_q   <= cls_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = res_q;
  assign status_out = stat_q;

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed vector table plus handshake,
// ignored-start and mid-conversion reset sequences.
module tb_fp_to_int;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic        busy;
  logic        done;
  logic [31:0] result_out;
  logic [3:0]  status_out;

  int n_pass;
  int n_tot;

  fp_to_int dut (
    .clock100KHz (clk),
    .reset       (reset),
    .start       (start),
    .op_in       (op_in),
    .busy        (busy),
    .done        (done),
    .result_out  (result_out),
    .status_out  (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] op;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  vec_t v[16];

  function automatic logic [31:0] fw(
    input logic s, input logic [5:0] e,
    input logic [24:0] m);
    return {s, e, m};
  endfunction

  function automatic vec_t mk(
    input string nm, input logic [31:0] op,
    input logic [31:0] res, input logic [3:0] st,
    input int lat);
    vec_t r;
    r.nm = nm; r.op = op; r.res = res;
    r.st = st; r.lat = lat;
    return r;
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  // Start one conversion; returns result, status, edges to done
  task automatic run(input logic [31:0] op,
    output logic [31:0] res, output logic [3:0] st,
    output int lat);
    @(negedge clk);
    op_in = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) chk("timeout", 32'(done), 32'd1);
    res = result_out;
    st  = status_out;
  endtask

  logic [31:0] r;
  logic [3:0]  s;
  int          l;
  int          nd;
  int          dl;
  logic [31:0] dr;

  initial begin
    n_pass = 0;
    n_tot  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op_in  = '0;

    v[0]  = mk("p1", fw(0,31,0), 32'h1, 4'b0000, 26);
    v[1]  = mk("m2", fw(1,32,0), 32'hFFFFFFFE, 4'b0001, 25);
    v[2]  = mk("zero", fw(0,0,0), 32'h0, 4'b0010, 1);
    v[3]  = mk("negz", fw(1,0,25'h1234), 32'h0, 4'b0010, 1);
    v[4]  = mk("psat", fw(0,63,0), 32'h7FFFFFFF, 4'b1000, 1);
    v[5]  = mk("nsat", fw(1,63,0), 32'h80000000, 4'b1001, 1);
    v[6]  = mk("min", fw(1,62,0), 32'h80000000, 4'b0001, 1);
    v[7]  = mk("p2e31", fw(0,62,0), 32'h7FFFFFFF, 4'b1000, 1);
    v[8]  = mk("e30", fw(0,61,25'h1FFFFFF), 32'h7FFFFFE0, 4'b0000, 6);
    v[9]  = mk("e25", fw(0,56,0), 32'h02000000, 4'b0000, 1);
    v[10] = mk("m0p125", fw(1,28,0), 32'h0, 4'b0110, 1);
    v[11] = mk("p4", fw(0,33,0), 32'h4, 4'b0000, 24);
`ifdef FP2INT_ROUND_EN
    v[12] = mk("p1p5", fw(0,31,25'h1000000), 32'h2, 4'b0100, 26);
    v[13] = mk("m2p5", fw(1,32,25'h0800000), 32'hFFFFFFFD, 4'b0101, 25);
    v[14] = mk("p0p5", fw(0,30,0), 32'h1, 4'b0100, 1);
    v[15] = mk("e24", fw(0,55,25'h1FFFFFF), 32'h02000000, 4'b0100, 2);
`else
    v[12] = mk("p1p5", fw(0,31,25'h1000000), 32'h1, 4'b0100, 26);
    v[13] = mk("m2p5", fw(1,32,25'h0800000), 32'hFFFFFFFE, 4'b0101, 25);
    v[14] = mk("p0p5", fw(0,30,0), 32'h0, 4'b0110, 1);
    v[15] = mk("e24", fw(0,55,25'h1FFFFFF), 32'h01FFFFFF, 4'b0100, 2);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", result_out, 32'd0);
    chk("rst_st", 32'(status_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // back-to-back: each start lands in the prior done cycle
    for (int i = 0; i < 16; i++) begin
      run(v[i].op, r, s, l);
      chk({v[i].nm, "_res"}, r, v[i].res);
      chk({v[i].nm, "_st"}, 32'(s), 32'(v[i].st));
      chk({v[i].nm, "_lat"}, 32'(l), 32'(v[i].lat));
    end

    // start on edge k+3 must be ignored
    @(negedge clk);
    op_in = fw(0,31,0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_rise", 32'(busy), 32'd1);
    nd = 0;
    dl = 0;
    dr = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1;
        op_in = fw(0,63,0);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (nd == 1) begin
          dl = i;
          dr = result_out;
        end
      end
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_lat", 32'(dl), 32'd26);
    chk("ign_res", dr, 32'h1);
    chk("ign_idle", 32'(busy), 32'd0);

    // reset during a conversion
    @(negedge clk);
    op_in = fw(0,31,0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_res", result_out, 32'd0);
    chk("mr_st", 32'(status_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("mr_nodone", 32'(nd), 32'd0);
    run(fw(0,33,0), r, s, l);
    chk("mr_p4_res", r, 32'h4);
    chk("mr_p4_st", 32'(s), 32'd0);
    chk("mr_p4_lat", 32'(l), 32'd24);
    @(posedge clk);
    #1;
    chk("done_fall", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Sequential converter from the FPU's 32-bit floating-point word to a signed 32-bit two's-complement integer. It sits downstream of `fpu` and consumes `data_out` for display, compare and control logic. It is the decoding counterpart of the FPU result path. Alignment uses an iterative one-bit-per-cycle shifter behind a start/done handshake.

## Interface
- No parameters; all widths come from `fp_pkg`.
- `clock100KHz`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only while `busy`=0
- `op_in`  in  32  operand {sign[31], exponent[30:25], mantissa[24:0]}
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse; `result_out` and `status_out` are valid from this cycle
- `result_out`  out  32  signed integer result; held until the next `done`
- `status_out`  out  4  [3] overflow/saturated, [2] inexact, [1] zero, [0] negative

## Operation
- Value encoding: (-1)^s × 1.m × 2^(e−31).
  - e=0 means zero, regardless of mantissa (denormals are flushed).
  - Unbiased exponent E = e−31, range −31..32.
- Significand register: 26 bits {1,m}. The shift count N is set by E:
  - E≥25: N = E−25, shift left.
  - 0≤E<25: N = 25−E, shift right.
  - Right shifts track a round bit and a sticky bit.
- Special cases, all with N=0 and no shifting:
  - Zero input.
  - E<0: magnitude 0, or 1 after rounding. Inexact is set.
  - E≥31: saturate. `result_out` is 0x7FFFFFFF for positive, 0x80000000 for negative, with overflow set. Exception: exactly −2^31 ({1,62,0}) returns 0x80000000 with no flags other than negative.
- States:
  - IDLE: on start, capture `op_in`, classify, and load N. Go to ROUND if N=0, else SHIFT.
  - SHIFT: one shift per cycle, N decrements. Go to ROUND when the last shift is done.
  - ROUND: apply rounding, then sign (two's-complement negate), then saturation. Register the outputs, pulse `done`, and return to IDLE.
- Rounding-up to a magnitude of 2^31 when positive counts as overflow and saturates.
- Inexact means discarded fraction bits were nonzero. It is never set together with overflow.
- The zero status bit reflects the integer result. Negative zero converts to 0 with the negative bit clear.

## Timing
- Reset value of every output: `busy`=0, `done`=0, `result_out`=0, `status_out`=0. State is IDLE.
- Latency: if `start` is sampled on edge k, `done` rises after edge k+N+1 and falls after edge k+N+2.
- Best case is 1 edge (N=0). Worst case is 26 edges (E=0, N=25).
- `busy` rises after edge k and falls on the same edge that raises `done`. A new `start` can be sampled in the `done` cycle.
- `start` while `busy`=1 is ignored. `op_in` is not sampled during a conversion.
- Reset asserted mid-conversion clears everything immediately. No `done` is produced. After reset releases, the next `start` behaves normally.

## Configuration
- `FP2INT_ROUND_EN` defined: round to nearest, ties away from zero. E=−1 yields ±1.
- Not defined: truncate toward zero. E<0 yields 0.
- Inexact flagging is identical in both builds.

## Structure
- `fp_pkg` holds:
  - Constants `EXP_W`=6, `MANT_W`=25, `BIAS`=31.
  - Packed struct `fp_word_t`.
  - Status bit index constants.
  - State enum `f2i_state_t`.
- One sub-module, `fp_unpack`: combinational split of `op_in` into sign, E, significand, and class (zero / normal / underflow / overflow).

## Test plan
- {0,31,0} (+1.0) → 0x00000001, status 0000. `done` rises 26 edges after `start`.
- {1,32,0} (−2.0) → 0xFFFFFFFE, status 0001. {0,0,0} → 0x00000000, status 0010, `done` 1 edge after `start`.
- {0,31,25'h1000000} (1.5) → 0x00000001 with status 0100 without `FP2INT_ROUND_EN`; 0x00000002 with status 0100 with it.
- {0,63,0} → 0x7FFFFFFF, status 1000. {1,63,0} → 0x80000000, status 1001. {1,62,0} → 0x80000000, status 0001.
- `start` pulsed again on edge k+3 during a +1.0 conversion → ignored; exactly one `done`, with value 1.
- `reset` low at edge k+5 of a +1.0 conversion → all outputs 0, no `done`. After release, {0,33,0} → 0x00000004 after 24 edges.
